w0rm_alu_divrem_seq: RTL and testbench

- Divide/remainder execution unit on the responder side of the ALU dispatch interface.
- The ALU core drives data_valid/opcode/data_a/data_b; this block returns result/result_valid/result_flags.
- Implements unsigned restoring division at one quotient bit per clock, with an optional single-cycle mode.
- The ALU core instantiates it once and demuxes its result by result_valid.

---
 rtl/w0rm_alu_divrem_seq.sv | 205 ++++++++++++++++++++
 tb/tb_w0rm_alu_divrem_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_alu_divrem_seq.sv
// ---------------------------------------------------------------------------
// w0rm_alu_divrem_seq
//
// Unsigned divide / remainder execution unit that responds to the ALU
// dispatch interface. A request is accepted when data_valid is high, busy is
// low and the opcode is DIV (4'h6) or REM (4'h7). Other requests are ignored.
//
// SINGLE_CYCLE = 0 : restoring division, one quotient bit per clock.
//                    result_valid pulses DATA_WIDTH+1 clocks after accept
//                    (1 clock after accept for divide-by-zero).
// SINGLE_CYCLE = 1 : combinational divide registered at the accept edge.
//                    result_valid pulses 1 clock after accept.
//
// Divide by zero returns quotient = all ones and remainder = dividend, with
// the overflow flag set.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   data_valid   in   request strobe, sampled while busy = 0
//   opcode       in   4'h6 DIV, 4'h7 REM
//   data_a       in   dividend
//   data_b       in   divisor
//   result       out  quotient or remainder, held until the next completion
//   result_valid out  one-clock pulse when result/result_flags update
//   result_flags out  {carry(=0), overflow, negative, zero}
//   busy         out  high while an accepted operation is in flight
// ---------------------------------------------------------------------------
module w0rm_alu_divrem_seq #(
  parameter int SINGLE_CYCLE = 0,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic [3:0]            result_flags,
  output logic                  busy
);

  localparam int         CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_REM = 4'h7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3   // single-cycle mode: result already written, busy one cycle
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;
  logic [DATA_WIDTH-1:0]   div_q, div_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    op_rem_q, op_rem_d;
  logic                    dbz_q, dbz_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [3:0]              flags_q, flags_d;
  logic                    rv_q, rv_d;

  logic                    accept;
  logic [DATA_WIDTH:0]     rem_sh;
  logic [DATA_WIDTH:0]     trial;
  logic [DATA_WIDTH-1:0]   fin_res;
  logic [DATA_WIDTH-1:0]   sc_quo;
  logic [DATA_WIDTH-1:0]   sc_rem;
  logic [DATA_WIDTH-1:0]   sc_res;

  // Flags are derived from the final result only; carry is never set.
  function automatic logic [3:0] make_flags(input logic [DATA_WIDTH-1:0] res,
                                            input logic                  ovf);
    make_flags = {1'b0, ovf, res[DATA_WIDTH-1], (res == '0)};
  endfunction

  assign accept = data_valid && (state_q == S_IDLE) &&
                  ((opcode == OP_DIV) || (opcode == OP_REM));

  // Combinational divider exists only in single-cycle mode.
  generate
    if (SINGLE_CYCLE != 0) begin : g_sc
      assign sc_quo = (data_b == '0) ? '1     : (data_a / data_b);
      assign sc_rem = (data_b == '0) ? data_a : (data_a % data_b);
    end else begin : g_iter
      assign sc_quo = '0;
      assign sc_rem = '0;
    end
  endgenerate

  assign sc_res = (opcode == OP_REM) ? sc_rem : sc_quo;

  // One restoring step: shift {rem,quo} left and try subtracting the divisor.
  // rem_sh needs one extra bit because it can reach 2*divisor-1.
  assign rem_sh  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial   = rem_sh - {1'b0, div_q};
  assign fin_res = op_rem_q ? rem_q : quo_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    op_rem_d = op_rem_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    flags_d  = flags_q;
    rv_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_rem_d = (opcode == OP_REM);
          dbz_d    = (data_b == '0);
          div_d    = data_b;
          if (SINGLE_CYCLE != 0) begin
            quo_d    = sc_quo;
            rem_d    = sc_rem;
            result_d = sc_res;
            flags_d  = make_flags(sc_res, (data_b == '0));
            rv_d     = 1'b1;
            state_d  = S_HOLD;
          end else if (data_b == '0) begin
            // Divide by zero skips the iteration entirely.
            quo_d   = '1;
            rem_d   = data_a;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = data_a;
            cnt_d   = CNT_W'(DATA_WIDTH - 1);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!trial[DATA_WIDTH]) begin
          rem_d = trial[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        result_d = fin_res;
        flags_d  = make_flags(fin_res, dbz_q);
        rv_d     = 1'b1;
        state_d  = S_IDLE;
      end

      S_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      op_rem_q <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      op_rem_q <= op_rem_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      rv_q     <= rv_d;
    end
  end

  assign result       = result_q;
  assign result_flags = flags_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_w0rm_alu_divrem_seq.sv
// ---------------------------------------------------------------------------
// Testbench for w0rm_alu_divrem_seq (iterative mode, 8-bit).
// Directed cases followed by randomized requests, each checked against a
// plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_w0rm_alu_divrem_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_valid;
  logic [3:0] opcode;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] result;
  logic       result_valid;
  logic [3:0] result_flags;
  logic       busy;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_rv = -100;

  w0rm_alu_divrem_seq #(
    .SINGLE_CYCLE(0),
    .DATA_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_valid  (data_valid),
    .opcode      (opcode),
    .data_a      (data_a),
    .data_b      (data_b),
    .result      (result),
    .result_valid(result_valid),
    .result_flags(result_flags),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic division with the divide-by-zero rules.
  function automatic void ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [3:0] f, output int lat);
    logic ovf;
    ovf = (b == 8'd0);
    if (op == 4'h7) r = ovf ? a : (a % b);
    else            r = ovf ? 8'hFF : (a / b);
    f   = {1'b0, ovf, r[7], (r == 8'd0)};
    lat = ovf ? 1 : 9;
  endfunction

  // Issues a request at the current time and waits for its result.
  // With noise set, data_valid stays high with random operands while busy.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit noise);
    logic [7:0] er;
    logic [3:0] ef;
    int         el;
    int         lat;
    int         bc;
    ref_op(op, a, b, er, ef, el);
    data_valid = 1'b1;
    opcode     = op;
    data_a     = a;
    data_b     = b;
    step();
    check("busy_after_accept", 32'(busy), 1);
    if (!noise) data_valid = 1'b0;
    lat = 0;
    bc  = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (result_valid) break;
      if (noise) begin
        data_a = 8'($urandom);
        data_b = 8'($urandom);
        opcode = 4'($urandom_range(6, 7));
      end
      step();
      lat++;
    end
    data_valid = 1'b0;
    check("rv_seen", 32'(result_valid), 1);
    check("latency", lat, el);
    check("busy_cycles", bc, el);
    check("result", 32'(result), 32'(er));
    check("flags", 32'(result_flags), 32'(ef));
    last_rv = cyc;
    $display("op=%0h a=0x%02h b=0x%02h -> result=0x%02h flags=%04b latency=%0d",
             op, a, b, result, result_flags, lat);
  endtask

  // Checks that result_valid was a single-cycle pulse and the unit is idle.
  task automatic after_op();
    data_valid = 1'b0;
    step();
    check("rv_pulse", 32'(result_valid), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] held;
    int         p;
    int         rv_cnt;
    logic [3:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;

    reset      = 1'b1;
    data_valid = 1'b0;
    opcode     = 4'h0;
    data_a     = 8'h00;
    data_b     = 8'h00;
    repeat (3) step();
    check("reset_result", 32'(result), 0);
    check("reset_flags", 32'(result_flags), 0);
    check("reset_rv", 32'(result_valid), 0);
    check("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    step();

    // Directed cases from the plan
    do_op(4'h6, 8'd100, 8'd7, 1'b0); after_op();
    do_op(4'h7, 8'd100, 8'd7, 1'b0); after_op();
    do_op(4'h7, 8'd0,   8'd5, 1'b0); after_op();
    do_op(4'h6, 8'h55,  8'd0, 1'b0); after_op();
    do_op(4'h7, 8'h55,  8'd0, 1'b0); after_op();
    do_op(4'h6, 8'hFF,  8'd1, 1'b0); after_op();
    do_op(4'h6, 8'd200, 8'd3, 1'b0); after_op();

    // Requests while busy are ignored
    do_op(4'h6, 8'd50, 8'd6, 1'b1); after_op();
    do_op(4'h7, 8'd251, 8'd13, 1'b1); after_op();

    // Back-to-back: next request on the edge right after result_valid
    do_op(4'h6, 8'd77, 8'd5, 1'b0);
    p = last_rv;
    do_op(4'h7, 8'd77, 8'd5, 1'b0);
    check("b2b_gap", last_rv - p, 10);
    after_op();

    // Unsupported opcodes do not start an operation
    held = result;
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1;
      opcode     = (i == 0) ? 4'h8 : 4'($urandom_range(8, 15));
      data_a     = 8'($urandom);
      data_b     = 8'($urandom_range(1, 255));
      step();
      check("badop_busy", 32'(busy), 0);
      check("badop_rv", 32'(result_valid), 0);
    end
    data_valid = 1'b0;
    check("badop_result_held", 32'(result), 32'(held));

    // Randomized requests
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(6, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      do_op(rop, ra, rb, ($urandom_range(0, 3) == 0));
      after_op();
    end

    // Leave a nonzero result so the reset clearing is visible
    do_op(4'h6, 8'd200, 8'd3, 1'b0); after_op();

    // Reset four cycles into the iteration aborts the operation
    data_valid = 1'b1;
    opcode     = 4'h6;
    data_a     = 8'd123;
    data_b     = 8'd4;
    step();
    data_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    check("abort_result", 32'(result), 0);
    check("abort_flags", 32'(result_flags), 0);
    check("abort_rv", 32'(result_valid), 0);
    check("abort_busy", 32'(busy), 0);
    reset  = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (result_valid) rv_cnt++;
    end
    check("abort_no_rv", rv_cnt, 0);
    check("abort_idle", 32'(busy), 0);

    do_op(4'h6, 8'd9, 8'd2, 1'b0); after_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
